strategy_adder_tree: RTL and testbench

Parametrised reduction adder for bit-plane partial results. Each column c takes NUM_ROWS signed row results and reduces them through a registered binary adder tree to one signed sum. The block sits between the PE array result outputs and the requantisation stage. Over the fixed 4x16 2-stage adder it adds generic sizes, a valid/ready handshake with backpressure, and per-beat mode selection (plain sum, MSB-plane negate, bypass).

---
 rtl/strategy_adder_pkg.sv | 30 +++
 rtl/strategy_adder_col.sv | 87 ++++++++
 rtl/strategy_adder_tree.sv | 145 ++++++++++++++
 tb/tb_strategy_adder_tree.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strategy_adder_pkg.sv
// Shared definitions for the bit-plane reduction adder: beat modes, the
// output width rule and the flat-bus slice index helpers.
package strategy_adder_pkg;

    // Per-beat leaf treatment; the reserved code reduces like MODE_SUM.
    typedef enum logic [1:0] {
        MODE_SUM     = 2'd0,
        MODE_MSB_NEG = 2'd1,
        MODE_BYPASS  = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    // Output width of a tree reducing `rows` signed inputs of `in_w` bits.
    function automatic int unsigned out_w(input int unsigned in_w, input int unsigned rows);
        return in_w + $clog2(rows);
    endfunction

    // LSB of row `row`, column `col` inside the flat i_data bus.
    function automatic int unsigned in_lsb(input int unsigned row, input int unsigned col,
                                           input int unsigned num_cols,
                                           input int unsigned in_w);
        return (row * num_cols + col) * in_w;
    endfunction

    // LSB of column `col` inside the flat o_data bus of `w`-bit lanes.
    function automatic int unsigned out_lsb(input int unsigned col, input int unsigned w);
        return col * w;
    endfunction

endpackage

// File: rtl/strategy_adder_col.sv
// One column of the reduction adder: applies the beat mode to the leaf
// operands and reduces them through a registered binary tree, one register
// level per tree level. All levels advance together when i_en is high.
module strategy_adder_col
    import strategy_adder_pkg::*;
#(
    parameter int unsigned  NUM_ROWS = 4,
    parameter int unsigned  IN_W     = 21,
    localparam int unsigned LVLS     = $clog2(NUM_ROWS),
    localparam int unsigned OUT_W    = out_w(IN_W, NUM_ROWS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic [1:0]               i_mode,
    input  logic [NUM_ROWS*IN_W-1:0] i_rows,
    output logic signed [OUT_W-1:0]  o_sum
);

    // Every node is kept at OUT_W. Only row NUM_ROWS-1 can reach +2^(IN_W-1)
    // after negation, so every partial sum of any subset of leaves fits in
    // OUT_W signed and the wider-per-level arithmetic gives identical results.
    logic signed [OUT_W-1:0] leaf [NUM_ROWS];
    mode_e                   mode;

    assign mode = mode_e'(i_mode);

    // Leaf preprocessing: sign-extend first so negating the most negative
    // input yields its positive magnitude instead of wrapping.
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            leaf[r] = OUT_W'($signed(i_rows[r*IN_W +: IN_W]));
            case (mode)
                MODE_MSB_NEG: begin
                    if (r == NUM_ROWS - 1) begin
                        leaf[r] = -leaf[r];
                    end
                end
                MODE_BYPASS: begin
                    if (r != 0) begin
                        leaf[r] = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < LVLS; k++) begin : g_lvl
        localparam int N = NUM_ROWS >> (k + 1);

        logic signed [OUT_W-1:0] node_d [N];
        logic signed [OUT_W-1:0] node_q [N];

        if (k == 0) begin : g_first
            // First level adds adjacent leaf pairs.
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    node_d[i] = leaf[2*i] + leaf[2*i+1];
                end
            end
        end else begin : g_inner
            // Later levels add adjacent pairs of the previous level's registers.
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    node_d[i] = g_lvl[k-1].node_q[2*i] + g_lvl[k-1].node_q[2*i+1];
                end
            end
        end

        // Level register; holds under stall.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < N; i++) begin
                    node_q[i] <= '0;
                end
            end else if (i_en) begin
                for (int i = 0; i < N; i++) begin
                    node_q[i] <= node_d[i];
                end
            end
        end
    end

    assign o_sum = g_lvl[LVLS-1].node_q[0];

endmodule

// File: rtl/strategy_adder_tree.sv
// Reduction adder for bit-plane partial results: NUM_COLS independent
// columns, each reducing NUM_ROWS signed rows through a registered tree.
// Owns the valid/ready handshake; the whole pipeline stalls globally.
// Optional build macro STRATEGY_ADDER_ACC_EN adds a per-column group
// accumulator after the tree that emits only on beats tagged i_last.
module strategy_adder_tree
    import strategy_adder_pkg::*;
#(
    parameter int unsigned  NUM_ROWS  = 4,
    parameter int unsigned  NUM_COLS  = 16,
    parameter int unsigned  IN_W      = 21,
    parameter int unsigned  ACC_GUARD = 8,
    localparam int unsigned LVLS      = $clog2(NUM_ROWS),
    localparam int unsigned OUT_W     = out_w(IN_W, NUM_ROWS),
`ifdef STRATEGY_ADDER_ACC_EN
    localparam int unsigned DATA_W    = OUT_W + ACC_GUARD
`else
    localparam int unsigned DATA_W    = OUT_W
`endif
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [1:0]                        i_mode,
    input  logic                              i_last,
    input  logic [NUM_ROWS*NUM_COLS*IN_W-1:0] i_data,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [NUM_COLS*DATA_W-1:0]        o_data
);

    logic                    advance;
    logic [LVLS-1:0]         vld_d, vld_q;
    logic signed [OUT_W-1:0] tree_sum [NUM_COLS];

    // The output register frees up when it is empty or being drained.
    assign advance = !o_valid || i_ready;
    assign o_ready = advance;

    // Stage valid bits; bubbles shift through with valid=0.
    always_comb begin
        vld_d = (vld_q << 1) | LVLS'(i_valid);
    end

    // Valid pipeline register, shifted on advance only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
        end else if (advance) begin
            vld_q <= vld_d;
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        logic [NUM_ROWS*IN_W-1:0] rows;

        for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
            assign rows[r*IN_W +: IN_W] = i_data[in_lsb(r, c, NUM_COLS, IN_W) +: IN_W];
        end

        strategy_adder_col #(
            .NUM_ROWS (NUM_ROWS),
            .IN_W     (IN_W)
        ) u_col (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_en     (advance),
            .i_mode   (i_mode),
            .i_rows   (rows),
            .o_sum    (tree_sum[c])
        );
    end

`ifdef STRATEGY_ADDER_ACC_EN

    logic [LVLS-1:0]          last_d, last_q;
    logic                     out_vld_q;
    logic                     first_q;
    logic signed [DATA_W-1:0] acc_d [NUM_COLS];
    logic signed [DATA_W-1:0] acc_q [NUM_COLS];

    // Group-end tag travels alongside the tree data.
    always_comb begin
        last_d = (last_q << 1) | LVLS'(i_last);
    end

    // Last-tag pipeline register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= '0;
        end else if (advance) begin
            last_q <= last_d;
        end
    end

    // Running sum; the first beat of a group loads instead of adding.
    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            acc_d[c] = (first_q ? '0 : acc_q[c]) + DATA_W'(tree_sum[c]);
        end
    end

    // Accumulator stage. acc_q doubles as the output register, so a group
    // total stays visible until drained; the next beat then reloads it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_vld_q <= 1'b0;
            first_q   <= 1'b1;
            for (int c = 0; c < NUM_COLS; c++) begin
                acc_q[c] <= '0;
            end
        end else if (advance) begin
            out_vld_q <= vld_q[LVLS-1] && last_q[LVLS-1];
            if (vld_q[LVLS-1]) begin
                first_q <= last_q[LVLS-1];
                for (int c = 0; c < NUM_COLS; c++) begin
                    acc_q[c] <= acc_d[c];
                end
            end
        end
    end

    assign o_valid = out_vld_q;

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_out
        assign o_data[out_lsb(c, DATA_W) +: DATA_W] = acc_q[c];
    end

`else

    // Group tagging and accumulator headroom have no role in this build.
    logic                   unused_last;
    localparam int unsigned unused_acc_guard = ACC_GUARD;

    assign unused_last = i_last;
    assign o_valid     = vld_q[LVLS-1];

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_out
        assign o_data[out_lsb(c, DATA_W) +: DATA_W] = tree_sum[c];
    end

`endif

endmodule

// File: tb/tb_strategy_adder_tree.sv
// Directed bench for strategy_adder_tree at default parameters. Also covers
// the group accumulator when built with STRATEGY_ADDER_ACC_EN.
module tb_strategy_adder_tree;

    localparam int NR = 4;
    localparam int NC = 16;
    localparam int IW = 21;
`ifdef STRATEGY_ADDER_ACC_EN
    localparam int DW  = 31;
    localparam int LAT = 3;
`else
    localparam int DW  = 23;
    localparam int LAT = 2;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_valid;
    logic              o_ready;
    logic [1:0]        i_mode;
    logic              i_last;
    logic [NR*NC*IW-1:0] i_data;
    logic              o_valid;
    logic              i_ready;
    logic [NC*DW-1:0]  o_data;

    int tests = 0;
    int fails = 0;

    strategy_adder_tree dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_mode  (i_mode),
        .i_last  (i_last),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_row(input int r, input int c, input int v);
        i_data[(r*NC+c)*IW +: IW] = v[IW-1:0];
    endtask

    task automatic fill_col(input int c, input int a, input int b, input int d, input int e);
        set_row(0, c, a);
        set_row(1, c, b);
        set_row(2, c, d);
        set_row(3, c, e);
    endtask

    task automatic fill_all(input int a, input int b, input int d, input int e);
        for (int c = 0; c < NC; c++) fill_col(c, a, b, d, e);
    endtask

    function automatic int get_col(input int c);
        logic signed [DW-1:0] t;
        t = o_data[c*DW +: DW];
        return int'(t);
    endfunction

    // One accepted beat tagged last; returns just after the accepting edge.
    task automatic send_one(input logic [1:0] mode);
        i_mode  = mode;
        i_last  = 1'b1;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_last  = 1'b1;
        i_mode  = 2'd0;
        i_data  = '0;
        #12;
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b expected 0", o_valid);
        end
        tests++;
        if (o_data !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h expected 0", o_data);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        tests++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got ready=%b valid=%b expected ready=1 valid=0",
                     o_ready, o_valid);
        end
    endtask

    task automatic test_sum();
        i_data = '0;
        fill_col(0, 1, 2, 3, 4);
        fill_col(15, -1, -1, -1, -1);
        send_one(2'd0);
        for (int i = 1; i < LAT; i++) begin
            tests++;
            if (o_valid !== 1'b0) begin
                fails++;
                $display("FAIL sum_early_valid: got %b expected 0 at cycle %0d", o_valid, i);
            end
            step();
        end
        tests++;
        if (o_valid !== 1'b1) begin
            fails++;
            $display("FAIL sum_latency: got valid=%b expected 1", o_valid);
        end
        tests++;
        if (get_col(0) !== 10 || get_col(15) !== -4 || get_col(7) !== 0) begin
            fails++;
            $display("FAIL sum_data: got col0=%0d col15=%0d col7=%0d expected 10 -4 0",
                     get_col(0), get_col(15), get_col(7));
        end
        step();
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL sum_single_out: got valid=%b expected 0", o_valid);
        end
    endtask

    task automatic test_msb_neg();
        i_data = '0;
        fill_all(0, 0, 0, -1048576);
        send_one(2'd1);
        repeat (LAT - 1) step();
        tests++;
        if (o_valid !== 1'b1) begin
            fails++;
            $display("FAIL msbneg_valid: got %b expected 1", o_valid);
        end
        for (int c = 0; c < NC; c++) begin
            tests++;
            if (get_col(c) !== 1048576) begin
                fails++;
                $display("FAIL msbneg_min col%0d: got %0d expected 1048576", c, get_col(c));
            end
        end
        fill_all(1048575, 1048575, 1048575, -1048576);
        send_one(2'd1);
        repeat (LAT - 1) step();
        tests++;
        if (o_valid !== 1'b1 || get_col(0) !== 4194301 || get_col(15) !== 4194301) begin
            fails++;
            $display("FAIL msbneg_max: got valid=%b col0=%0d col15=%0d expected 1 4194301",
                     o_valid, get_col(0), get_col(15));
        end
    endtask

    task automatic test_bypass();
        i_data = '0;
        fill_all(7, 100, 100, 100);
        send_one(2'd2);
        repeat (LAT - 1) step();
        tests++;
        if (o_valid !== 1'b1 || get_col(0) !== 7 || get_col(9) !== 7) begin
            fails++;
            $display("FAIL bypass: got valid=%b col0=%0d col9=%0d expected 1 7 7",
                     o_valid, get_col(0), get_col(9));
        end
        send_one(2'd3);
        repeat (LAT - 1) step();
        tests++;
        if (o_valid !== 1'b1 || get_col(0) !== 307) begin
            fails++;
            $display("FAIL reserved_mode: got valid=%b col0=%0d expected 1 307",
                     o_valid, get_col(0));
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] modes [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
        int         vals  [4] = '{1, 1, 5, 5};
        int         expv  [4] = '{10, 1, 20, 5};
        int         got [$];
        i_data = '0;
        i_last = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc < 4) begin
                i_mode  = modes[cyc];
                i_valid = 1'b1;
                if (vals[cyc] == 1) fill_col(0, 1, 2, 3, 4);
                else fill_col(0, 5, 5, 5, 5);
            end else begin
                i_valid = 1'b0;
            end
            step();
            if (o_valid) got.push_back(get_col(0));
        end
        tests++;
        if (got.size() !== 4) begin
            fails++;
            $display("FAIL b2b_count: got %0d expected 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== expv[i]) begin
                fails++;
                $display("FAIL b2b_beat%0d: got %0d expected %0d", i, got[i], expv[i]);
            end
        end
    endtask

    task automatic test_stall();
        int idx = 0;
        int n_stall = 0;
        int got0 [$];
        int got3 [$];
        bit acc;
        bit stalled;
        int prev;
        i_data = '0;
        i_mode = 2'd0;
        i_last = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            i_ready = !(cyc >= 5 && cyc < 8);
            if (idx < 10) begin
                i_valid = 1'b1;
                fill_col(0, idx + 1, 0, 0, 0);
                fill_col(3, idx + 1, idx + 1, idx + 1, idx + 1);
            end else begin
                i_valid = 1'b0;
            end
            #2;
            acc     = i_valid && o_ready;
            stalled = o_valid && !i_ready;
            prev    = get_col(0);
            if (stalled) begin
                n_stall++;
                tests++;
                if (o_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_ready cyc%0d: got %b expected 0", cyc, o_ready);
                end
            end
            if (o_valid && i_ready) begin
                got0.push_back(get_col(0));
                got3.push_back(get_col(3));
            end
            step();
            if (acc) idx++;
            if (stalled) begin
                tests++;
                if (o_valid !== 1'b1 || get_col(0) !== prev) begin
                    fails++;
                    $display("FAIL stall_hold cyc%0d: got valid=%b col0=%0d expected 1 %0d",
                             cyc, o_valid, get_col(0), prev);
                end
            end
            if (idx == 10 && got0.size() == 10) break;
        end
        i_ready = 1'b1;
        i_valid = 1'b0;
        tests++;
        if (n_stall !== 3) begin
            fails++;
            $display("FAIL stall_cycles: got %0d expected 3", n_stall);
        end
        tests++;
        if (got0.size() !== 10) begin
            fails++;
            $display("FAIL stall_count: got %0d expected 10", got0.size());
        end
        for (int i = 0; i < got0.size() && i < 10; i++) begin
            tests++;
            if (got0[i] !== i + 1 || got3[i] !== 4 * (i + 1)) begin
                fails++;
                $display("FAIL stall_order beat%0d: got col0=%0d col3=%0d expected %0d %0d",
                         i, got0[i], got3[i], i + 1, 4 * (i + 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        i_data = '0;
        fill_col(0, 1, 1, 1, 1);
        i_mode  = 2'd0;
        i_last  = 1'b1;
        i_valid = 1'b1;
        step();
        step();
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        tests++;
        if (o_valid !== 1'b0 || o_data !== '0) begin
            fails++;
            $display("FAIL midreset_clear: got valid=%b data=%h expected 0 0", o_valid, o_data);
        end
        step();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            step();
            if (o_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL midreset_partial: got %0d outputs expected 0", seen);
        end
        fill_col(0, 2, 3, 4, 5);
        send_one(2'd0);
        repeat (LAT - 1) step();
        tests++;
        if (o_valid !== 1'b1 || get_col(0) !== 14) begin
            fails++;
            $display("FAIL midreset_fresh: got valid=%b col0=%0d expected 1 14",
                     o_valid, get_col(0));
        end
    endtask

`ifdef STRATEGY_ADDER_ACC_EN
    task automatic test_acc_group();
        int n_out = 0;
        int val = 0;
        i_data = '0;
        i_mode = 2'd0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            if (cyc < 3) begin
                i_valid = 1'b1;
                i_last  = (cyc == 2);
                if (cyc == 0) fill_col(0, 1, 2, 3, 4);
                else if (cyc == 1) fill_col(0, 5, 5, 5, 5);
                else fill_col(0, -1, -1, -1, -2);
            end else begin
                i_valid = 1'b0;
            end
            step();
            if (o_valid) begin
                n_out++;
                val = get_col(0);
            end
        end
        tests++;
        if (n_out !== 1 || val !== 25) begin
            fails++;
            $display("FAIL acc_group: got outputs=%0d col0=%0d expected 1 25", n_out, val);
        end
        fill_col(0, 1, 1, 1, 1);
        send_one(2'd0);
        repeat (LAT - 1) step();
        tests++;
        if (o_valid !== 1'b1 || get_col(0) !== 4) begin
            fails++;
            $display("FAIL acc_restart: got valid=%b col0=%0d expected 1 4",
                     o_valid, get_col(0));
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sum();
        test_msb_neg();
        test_bypass();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef STRATEGY_ADDER_ACC_EN
        test_acc_group();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
